// File: rtl/ctrl_pipe.sv
// Control-word pipeline from ID through EX, MEM and WB. Detects load-use hazards,
// requests a one-cycle IF/ID stall, injects bubbles into EX and counts bubbles.
module ctrl_pipe #(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned ALU_W  = 5,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] id_muxctrl,
    input  logic [2:0]        id_memctrl,
    input  logic [ALU_W-1:0]  id_aluctrl,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              flush,
    output logic              stall,
    output logic [CTRL_W-1:0] ex_muxctrl,
    output logic [2:0]        ex_memctrl,
    output logic [ALU_W-1:0]  ex_aluctrl,
    output logic [REG_AW-1:0] ex_dest,
    output logic [2:0]        mem_memctrl,
    output logic [REG_AW-1:0] mem_dest,
    output logic              wb_regwrite,
    output logic              wb_mem_to_reg,
    output logic [REG_AW-1:0] wb_dest,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned      MEM_RD_BIT  = 2;
    localparam int unsigned      MEM_REG_BIT = 0;
    localparam int unsigned      M2R_BIT     = 2;
    localparam logic [ALU_W-1:0] NOOP_ALU    = ALU_W'(5'b01101);

    logic hazard;
    logic bubble_ex;
    // Only the mem_to_reg bit of muxctrl is consumed beyond EX.
    logic mem_mem_to_reg;

    // Load in EX whose destination feeds the ID instruction.
    always_comb begin
        hazard = ex_memctrl[MEM_RD_BIT]
               & (ex_dest != '0)
               & ((ex_dest == id_rs) | (ex_dest == id_rt));
        stall     = hazard & ~flush;
        bubble_ex = flush | hazard;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_muxctrl     <= '0;
            ex_memctrl     <= '0;
            ex_aluctrl     <= NOOP_ALU;
            ex_dest        <= '0;
            mem_memctrl    <= '0;
            mem_dest       <= '0;
            mem_mem_to_reg <= 1'b0;
            wb_regwrite    <= 1'b0;
            wb_mem_to_reg  <= 1'b0;
            wb_dest        <= '0;
            stall_cnt      <= '0;
            flush_cnt      <= '0;
        end else begin
            if (bubble_ex) begin
                ex_muxctrl <= '0;
                ex_memctrl <= '0;
                ex_aluctrl <= NOOP_ALU;
                ex_dest    <= '0;
            end else begin
                ex_muxctrl <= id_muxctrl;
                ex_memctrl <= id_memctrl;
                ex_aluctrl <= id_aluctrl;
                ex_dest    <= id_dest;
            end

            mem_memctrl    <= ex_memctrl;
            mem_dest       <= ex_dest;
            mem_mem_to_reg <= ex_muxctrl[M2R_BIT];

            // Register 0 is hard-wired, so writes to it are dropped here.
            wb_regwrite   <= mem_memctrl[MEM_REG_BIT] & (mem_dest != '0);
            wb_mem_to_reg <= mem_mem_to_reg;
            wb_dest       <= mem_dest;

            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
